poly_voice_engine: RTL



---
 rtl/synth_pkg.sv | 29 ++
 rtl/poly_voice_engine_wave_shaper.sv | 32 +++
 rtl/poly_voice_engine.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/synth_pkg.sv
// Shared types and helper constants for the polyphonic voice engine.
package synth_pkg;

    typedef enum logic [1:0] {
        SQUARE   = 2'd0,
        SAW      = 2'd1,
        TRIANGLE = 2'd2,
        OFF      = 2'd3
    } wave_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        MIX  = 2'd2
    } eng_state_t;

    function automatic longint full_scale(input int w);
        return (longint'(1) << w) - 1;
    endfunction

    function automatic longint sat_max(input int w);
        return (longint'(1) << (w - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int w);
        return -(longint'(1) << (w - 1));
    endfunction

endpackage

// File: rtl/poly_voice_engine_wave_shaper.sv
// Combinational waveform generator: maps the top phase bits of one voice
// to a signed square, saw or triangle sample.
module wave_shaper
    import synth_pkg::*;
#(
    parameter int OUT_W = 16
) (
    input  logic        [OUT_W-1:0] top_bits,
    input  wave_t                   wave,
    output logic signed [OUT_W-1:0] value
);

    localparam logic [OUT_W-1:0] HALF    = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic [OUT_W-1:0] POS_MAX = {1'b0, {(OUT_W-1){1'b1}}};

    logic [OUT_W-1:0] doubled;

    // Offsetting by half scale modulo 2^OUT_W is a flip of the MSB, and
    // (half-1) - x is x xor (half-1), so every shape is just bit logic.
    always_comb begin
        doubled = {top_bits[OUT_W-2:0], 1'b0};
        value   = '0;
        case (wave)
            SQUARE:   value = top_bits[OUT_W-1] ? HALF : POS_MAX;
            SAW:      value = top_bits ^ HALF;
            TRIANGLE: value = top_bits[OUT_W-1] ? (doubled ^ POS_MAX) : (doubled ^ HALF);
            OFF:      value = '0;
            default:  value = '0;
        endcase
    end

endmodule

// File: rtl/poly_voice_engine.sv
// Time-multiplexed polyphonic oscillator: one voice per cycle through a shared
// wave/envelope datapath, then a master-volume mix with saturation.
module poly_voice_engine
    import synth_pkg::*;
#(
    parameter int NUM_VOICES = 16,
    parameter int PHASE_W    = 32,
    parameter int OUT_W      = 16,
    parameter int ENV_W      = 12,
    parameter int MIX_SHIFT  = 4
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           sample_tick,
    input  logic [NUM_VOICES*PHASE_W-1:0]  phase_inc,
    input  logic [NUM_VOICES*2-1:0]        wave_sel,
    input  logic [NUM_VOICES-1:0]          gate,
    input  logic [ENV_W-1:0]               attack_rate,
    input  logic [ENV_W-1:0]               release_rate,
    input  logic [7:0]                     volume,
    output logic signed [OUT_W-1:0]        sample_out,
    output logic                           sample_valid,
    output logic                           busy,
    output logic                           overrun
);

    localparam int VIDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int ACC_W  = OUT_W + $clog2(NUM_VOICES) + 1;
    localparam int PROD_W = OUT_W + ENV_W + 1;
    localparam int MIX_W  = ACC_W + 9;
    localparam int ENV_W1 = ENV_W + 1;

    localparam logic [ENV_W:0]            ENV_MAX    = ENV_W1'(full_scale(ENV_W));
    localparam logic signed [MIX_W-1:0]   SAT_HI     = MIX_W'(sat_max(OUT_W));
    localparam logic signed [MIX_W-1:0]   SAT_LO     = MIX_W'(sat_min(OUT_W));
    localparam logic [VIDX_W-1:0]         LAST_VOICE = VIDX_W'(NUM_VOICES - 1);

    eng_state_t state, state_next;

    logic [VIDX_W-1:0]       voice;
    logic signed [ACC_W-1:0] acc;
    logic [PHASE_W-1:0]      phase [NUM_VOICES];
    logic [ENV_W-1:0]        env   [NUM_VOICES];

    logic [PHASE_W-1:0]       cur_phase;
    logic [PHASE_W-1:0]       cur_inc;
    logic [ENV_W-1:0]         cur_env;
    logic                     cur_gate;
    wave_t                    cur_wave;
    logic signed [OUT_W-1:0]  wave_val;
    logic [ENV_W:0]           env_up;
    logic [ENV_W-1:0]         env_new;
    logic signed [PROD_W-1:0] voice_prod;
    logic signed [PROD_W-1:0] voice_scaled;
    logic signed [MIX_W-1:0]  mix_prod;
    logic signed [MIX_W-1:0]  mix_scaled;
    logic signed [OUT_W-1:0]  mix_sat;

    assign cur_phase = phase[voice];
    assign cur_env   = env[voice];
    assign cur_inc   = phase_inc[voice*PHASE_W +: PHASE_W];
    assign cur_wave  = wave_t'(wave_sel[voice*2 +: 2]);
    assign cur_gate  = gate[voice];
    assign busy      = (state != IDLE);

    wave_shaper #(.OUT_W(OUT_W)) u_wave_shaper (
        .top_bits (cur_phase[PHASE_W-1 -: OUT_W]),
        .wave     (cur_wave),
        .value    (wave_val)
    );

    // Saturating envelope step, then scale the wave by the freshly updated envelope.
    always_comb begin
        env_up = {1'b0, cur_env} + {1'b0, attack_rate};
        if (cur_gate) begin
            env_new = (env_up > ENV_MAX) ? ENV_MAX[ENV_W-1:0] : env_up[ENV_W-1:0];
        end else begin
            env_new = (cur_env > release_rate) ? (cur_env - release_rate) : '0;
        end
        voice_prod   = PROD_W'(wave_val) * PROD_W'($signed({1'b0, env_new}));
        voice_scaled = voice_prod >>> ENV_W;
    end

    always_comb begin
        mix_prod   = MIX_W'(acc) * MIX_W'($signed({1'b0, volume}));
        mix_scaled = mix_prod >>> (7 + MIX_SHIFT);
        if (mix_scaled > SAT_HI) begin
            mix_sat = SAT_HI[OUT_W-1:0];
        end else if (mix_scaled < SAT_LO) begin
            mix_sat = SAT_LO[OUT_W-1:0];
        end else begin
            mix_sat = mix_scaled[OUT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (sample_tick) state_next = RUN;
            RUN:     if (voice == LAST_VOICE) state_next = MIX;
            MIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Phase and envelope advance for every voice slot, even when the voice is off.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                phase[i] <= '0;
                env[i]   <= '0;
            end
            voice        <= '0;
            acc          <= '0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            if (sample_tick && (state != IDLE)) begin
                overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (sample_tick) begin
                        acc   <= '0;
                        voice <= '0;
                    end
                end
                RUN: begin
                    phase[voice] <= cur_phase + cur_inc;
                    env[voice]   <= env_new;
                    acc          <= acc + ACC_W'(voice_scaled);
                    voice        <= voice + 1'b1;
                end
                MIX: begin
                    sample_out   <= mix_sat;
                    sample_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
